// File: rtl/axi_lite_traffic_gen.sv
// AXI4-Lite master traffic generator.
// Runs num_txn write-then-readback pairs with an LFSR data pattern, checks the
// read data and reports pass/fail plus counters. Intended to drive the user
// AXI-Lite port of the AIB AXI bridge master during bring-up and loopback.
//
// Build option: define AXI_TG_RANDOM_STRB_EN to draw wstrb from the LFSR
// (forced to all-ones when zero) and mask the readback compare to the strobed
// bytes. Without it, wstrb is all-ones and the full word is compared.
//
// Handshake rule on every channel: a transfer happens on a rising edge of
// clk_wr where valid and ready are both 1. Once this block raises a valid, the
// matching address/data/strobe outputs stay constant until that transfer; the
// valid drops the cycle after the transfer. The only exception is the timeout
// abort, which drops every valid/ready on purpose.
//
// fsm_state exposes the controller state for debug and checkers:
// 0 IDLE, 1 WR, 2 WB, 3 RD, 4 RR, 5 NEXT, 6 DONE.

module axi_lite_traffic_gen #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk_wr,
  input  logic                rst_wr_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         num_txn,
  input  logic [31:0]         seed,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [15:0]         txn_count,
  output logic                timeout_err,
  output logic [2:0]          fsm_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WB   = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_RR   = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]       num_q;
  logic [31:0]       lfsr;
  logic [31:0]       lfsr_nxt;
  logic [31:0]       seed_eff;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic              aw_done;
  logic              w_done;

  logic              start_ok;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              ar_hs;
  logic              r_hs;
  logic              in_wait;
  logic              timed_out;
  logic              abort;
  logic              last_txn;
  logic              rd_bad;
  logic              err_hit;

  logic [DATA_W-1:0] pat_seed;
  logic [DATA_W-1:0] pat_nxt;
  logic [STRB_W-1:0] strb_seed;
  logic [STRB_W-1:0] strb_nxt;
  logic [DATA_W-1:0] cmp_mask;

  assign fsm_state = state;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign pass      = done && (err_count == 16'd0) && !timeout_err;

  // A new run is only accepted when no run is in progress.
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign seed_eff  = (seed == 32'd0) ? 32'd1 : seed;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // Galois LFSR, right-shifting, polynomial x^32+x^22+x^2+x+1.
  assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign addr_nxt = cur_addr + ADDR_W'(4);

  assign in_wait   = (state == S_WR) || (state == S_WB) ||
                     (state == S_RD) || (state == S_RR);
  assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign last_txn  = ((txn_count + 16'd1) == num_q);

  // The data word repeats the 32-bit LFSR value across wider buses.
  genvar g;
  generate
    for (g = 0; g < DATA_W; g++) begin : g_pat
      assign pat_seed[g] = seed_eff[g % 32];
      assign pat_nxt[g]  = lfsr_nxt[g % 32];
    end
    for (g = 0; g < STRB_W; g++) begin : g_mask
      assign cmp_mask[g*8 +: 8] = {8{wstrb[g]}};
    end
  endgenerate

`ifdef AXI_TG_RANDOM_STRB_EN
  logic [STRB_W-1:0] strb_seed_raw;
  logic [STRB_W-1:0] strb_nxt_raw;

  generate
    for (g = 0; g < STRB_W; g++) begin : g_strb
      assign strb_seed_raw[g] = seed_eff[g % 32];
      assign strb_nxt_raw[g]  = lfsr_nxt[g % 32];
    end
  endgenerate

  // An all-zero strobe would write nothing, so it is promoted to a full word.
  assign strb_seed = (strb_seed_raw == '0) ? '1 : strb_seed_raw;
  assign strb_nxt  = (strb_nxt_raw == '0) ? '1 : strb_nxt_raw;
`else
  assign strb_seed = '1;
  assign strb_nxt  = '1;
`endif

  // wdata/wstrb hold the expected word and its strobe until the next launch,
  // so the readback compare uses them directly.
  assign rd_bad = (((rdata ^ wdata) & cmp_mask) != '0) || (rresp != 2'b00);

  // Next-state selection; a handshake completing on the last allowed cycle
  // wins over the timeout.
  always_comb begin
    state_nxt = state;
    err_hit   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) state_nxt = (num_txn == 16'd0) ? S_DONE : S_WR;
      end
      S_WR: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WB;
        else if (timed_out)                          state_nxt = S_DONE;
      end
      S_WB: begin
        if (b_hs) begin
          state_nxt = S_RD;
          err_hit   = (bresp != 2'b00);
        end else if (timed_out) begin
          state_nxt = S_DONE;
        end
      end
      S_RD: begin
        if (ar_hs)          state_nxt = S_RR;
        else if (timed_out) state_nxt = S_DONE;
      end
      S_RR: begin
        if (r_hs) begin
          state_nxt = S_NEXT;
          err_hit   = rd_bad;
        end else if (timed_out) begin
          state_nxt = S_DONE;
        end
      end
      S_NEXT: begin
        state_nxt = last_txn ? S_DONE : S_WR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign abort = in_wait && (state_nxt == S_DONE);

  // State register and per-state wait counter (cleared on every state entry).
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) wait_cnt <= '0;
      else if (in_wait)       wait_cnt <= wait_cnt + 1'b1;
      else                    wait_cnt <= '0;
    end
  end

  // AXI channel outputs: launch, per-channel completion and abort.
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      awaddr  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      araddr  <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (start_ok && (num_txn != 16'd0)) begin
        awaddr  <= base_addr;
        awvalid <= 1'b1;
        wdata   <= pat_seed;
        wstrb   <= strb_seed;
        wvalid  <= 1'b1;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      case (state)
        S_WR: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (state_nxt == S_WB) bready <= 1'b1;
        end
        S_WB: begin
          if (state_nxt == S_RD) begin
            bready  <= 1'b0;
            arvalid <= 1'b1;
            araddr  <= cur_addr;
          end
        end
        S_RD: begin
          if (state_nxt == S_RR) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        S_RR: begin
          if (state_nxt == S_NEXT) rready <= 1'b0;
        end
        S_NEXT: begin
          if (state_nxt == S_WR) begin
            awaddr  <= addr_nxt;
            awvalid <= 1'b1;
            wdata   <= pat_nxt;
            wstrb   <= strb_nxt;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: ;
      endcase
      if (abort) begin
        awvalid <= 1'b0;
        wvalid  <= 1'b0;
        bready  <= 1'b0;
        arvalid <= 1'b0;
        rready  <= 1'b0;
      end
    end
  end

  // Run bookkeeping: latched run parameters, LFSR, address and result counters.
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      num_q       <= 16'd0;
      lfsr        <= 32'd1;
      cur_addr    <= '0;
      err_count   <= 16'd0;
      txn_count   <= 16'd0;
      timeout_err <= 1'b0;
    end else if (start_ok) begin
      num_q       <= num_txn;
      lfsr        <= seed_eff;
      cur_addr    <= base_addr;
      err_count   <= 16'd0;
      txn_count   <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_NEXT) begin
        txn_count <= txn_count + 16'd1;
        lfsr      <= lfsr_nxt;
        cur_addr  <= addr_nxt;
      end
      if (err_hit && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      if (abort) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_lite_traffic_gen.sv
// Bench for axi_lite_traffic_gen: a memory slave with fault knobs, a monitor
// that pops expected AW/W/AR beats from queues, and directed runs.

module tb_axi_lite_traffic_gen;

  logic        clk_wr = 1'b0;
  logic        rst_wr_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_txn;
  logic [31:0] seed;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] txn_count;
  logic        timeout_err;
  logic [2:0]  fsm_state;

  axi_lite_traffic_gen #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .start(start), .base_addr(base_addr),
    .num_txn(num_txn), .seed(seed),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .txn_count(txn_count), .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk_wr = ~clk_wr;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] exp_ar_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  int aw_hs_cnt = 0, b_hs_cnt = 0, w_first_cnt = 0;
  int last_aw_held = 0, last_ar_held = 0;

  // slave knobs (index = (addr - base_addr) / 4)
  int aw_delay  = 0;
  int xor_idx   = -1;
  int bresp_idx = -1;
  bit ar_block  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] d;
    d = (a - base_addr) >> 2;
    return int'(d);
  endfunction

  // ---------------- memory slave (acts #1 after each rising edge) ----------------
  logic [31:0] mem [logic [31:0]];
  initial begin
    bit aw_p, w_p, b_p, ar_p, r_p, aw_got, w_got;
    logic [31:0] p_awaddr, p_wdata, p_araddr, s_awaddr, s_wdata, rd;
    int aw_wait;
    aw_p = 0; w_p = 0; b_p = 0; ar_p = 0; r_p = 0; aw_got = 0; w_got = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; s_awaddr = 0; s_wdata = 0; aw_wait = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(posedge clk_wr);
      #1;
      if (!rst_wr_n) begin
        aw_p = 0; w_p = 0; b_p = 0; ar_p = 0; r_p = 0; aw_got = 0; w_got = 0; aw_wait = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0;
        continue;
      end
      if (r_p) rvalid = 0;
      if (b_p) bvalid = 0;
      if (aw_p) begin aw_got = 1; s_awaddr = p_awaddr; end
      if (w_p)  begin w_got = 1;  s_wdata  = p_wdata;  end
      if (aw_got && w_got && !bvalid) begin
        mem[s_awaddr] = s_wdata;
        bvalid = 1;
        bresp  = (idx_of(s_awaddr) == bresp_idx) ? 2'b10 : 2'b00;
        aw_got = 0; w_got = 0;
      end
      if (ar_p) begin
        rd     = mem.exists(p_araddr) ? mem[p_araddr] : 32'h0;
        rdata  = (idx_of(p_araddr) == xor_idx) ? (rd ^ 32'h1) : rd;
        rresp  = 2'b00;
        rvalid = 1;
      end
      if (awvalid && !aw_got) begin
        if (aw_wait >= aw_delay) awready = 1;
        else begin awready = 0; aw_wait++; end
      end else begin
        awready = 0; aw_wait = 0;
      end
      wready  = wvalid && !w_got;
      arready = arvalid && !ar_block && !rvalid;
      aw_p = awvalid && awready; p_awaddr = awaddr;
      w_p  = wvalid && wready;   p_wdata  = wdata;
      b_p  = bvalid && bready;
      ar_p = arvalid && arready; p_araddr = araddr;
      r_p  = rvalid && rready;
    end
  end

  // ---------------- monitor: pops expected beats on each handshake ----------------
  initial begin
    bit prev_awvalid, prev_wvalid, prev_arvalid;
    logic [31:0] prev_awaddr, prev_wdata;
    int aw_run, ar_run;
    prev_awvalid = 0; prev_wvalid = 0; prev_arvalid = 0;
    prev_awaddr = 0; prev_wdata = 0; aw_run = 0; ar_run = 0;
    forever begin
      @(negedge clk_wr);
      if (!rst_wr_n) begin
        prev_awvalid = 0; prev_wvalid = 0; prev_arvalid = 0; aw_run = 0; ar_run = 0;
        continue;
      end
      if (awvalid) begin
        if (prev_awvalid) check("awaddr_stable", awaddr, prev_awaddr);
        aw_run = prev_awvalid ? aw_run + 1 : 1;
        if (awready) begin
          aw_hs_cnt++;
          last_aw_held = aw_run;
          if (exp_aw_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL aw_unexpected: got %0h expected none", awaddr);
          end else check("awaddr", awaddr, exp_aw_q.pop_front());
        end
      end
      if (wvalid) begin
        if (prev_wvalid) check("wdata_stable", wdata, prev_wdata);
        if (wready) begin
          if (awvalid && !awready) w_first_cnt++;
          check("wstrb", wstrb, 4'hF);
          if (exp_w_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL w_unexpected: got %0h expected none", wdata);
          end else check("wdata", wdata, exp_w_q.pop_front());
        end
      end
      if (arvalid) begin
        ar_run = prev_arvalid ? ar_run + 1 : 1;
        if (arready) begin
          if (exp_ar_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL ar_unexpected: got %0h expected none", araddr);
          end else check("araddr", araddr, exp_ar_q.pop_front());
        end
      end
      if (prev_arvalid && !arvalid) last_ar_held = ar_run;
      if (bvalid && bready) b_hs_cnt++;
      prev_awvalid = awvalid; prev_awaddr = awaddr;
      prev_wvalid  = wvalid;  prev_wdata  = wdata;
      prev_arvalid = arvalid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_txn(input logic [31:0] a, input logic [31:0] d);
    exp_aw_q.push_back(a);
    exp_w_q.push_back(d);
    exp_ar_q.push_back(a);
  endtask

  task automatic push_seed_run(input logic [31:0] base);
    // LFSR sequence from seed DEADBEEF, worked by hand
    push_txn(base,        32'hDEAD_BEEF);
    push_txn(base + 32'd4,  32'hEF76_DF74);
    push_txn(base + 32'd8,  32'h77BB_6FBA);
    push_txn(base + 32'd12, 32'h3BDD_B7DD);
  endtask

  task automatic clear_queues();
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    aw_hs_cnt = 0; b_hs_cnt = 0; w_first_cnt = 0; last_aw_held = 0; last_ar_held = 0;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
    @(negedge clk_wr);
    base_addr = b; num_txn = n; seed = s; start = 1'b1;
    @(negedge clk_wr);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk_wr);
      k++;
    end
    check({name, "_done"}, done, 1'b1);
  endtask

  task automatic check_queues(input string name);
    check({name, "_aw_left"}, 64'(exp_aw_q.size()), 0);
    check({name, "_w_left"},  64'(exp_w_q.size()), 0);
    check({name, "_ar_left"}, 64'(exp_ar_q.size()), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valids"}, {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_cnts"}, {err_count, txn_count}, 32'h0);
    check({name, "_flags"}, {done, pass, timeout_err}, 3'b0);
    check({name, "_state"}, fsm_state, 3'd0);
    check({name, "_addr_data"}, {awaddr, wdata, araddr}, 96'h0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_wr_n = 1'b0; start = 1'b0; base_addr = 32'h0; num_txn = 16'd0; seed = 32'h0;
    repeat (3) @(negedge clk_wr);
    check_idle_outputs("reset");
    rst_wr_n = 1'b1;
    @(negedge clk_wr);

    // T1: zero-wait slave; a start while busy must be ignored
    clear_queues();
    push_seed_run(32'hA000_0000);
    pulse_start(32'hA000_0000, 16'd4, 32'hDEAD_BEEF);
    check("t1_busy", busy, 1'b1);
    repeat (4) @(negedge clk_wr);
    base_addr = 32'h5555_0000; start = 1'b1;
    @(negedge clk_wr);
    start = 1'b0; base_addr = 32'hA000_0000;
    wait_done("t1", 400);
    check("t1_txn", txn_count, 16'd4);
    check("t1_err", err_count, 16'd0);
    check("t1_pass", {pass, timeout_err, busy}, 3'b100);
    check("t1_b_cnt", 64'(b_hs_cnt), 4);
    check_queues("t1");

    // T2: AW stalled 3 cycles, W immediate
    clear_queues();
    aw_delay = 3;
    push_seed_run(32'hA000_0000);
    pulse_start(32'hA000_0000, 16'd4, 32'hDEAD_BEEF);
    wait_done("t2", 600);
    check("t2_aw_held", 64'(last_aw_held), 4);
    check("t2_w_first", 64'(w_first_cnt), 4);
    check("t2_aw_cnt", 64'(aw_hs_cnt), 4);
    check("t2_b_cnt", 64'(b_hs_cnt), 4);
    check("t2_pass", pass, 1'b1);
    check_queues("t2");
    aw_delay = 0;

    // T3: corrupted readback on index 2
    clear_queues();
    xor_idx = 2;
    push_seed_run(32'hA000_0000);
    pulse_start(32'hA000_0000, 16'd4, 32'hDEAD_BEEF);
    wait_done("t3", 400);
    check("t3_err", err_count, 16'd1);
    check("t3_txn", txn_count, 16'd4);
    check("t3_pass", pass, 1'b0);
    check_queues("t3");
    xor_idx = -1;

    // T4: SLVERR on the first write response
    clear_queues();
    bresp_idx = 0;
    push_seed_run(32'hA000_0000);
    pulse_start(32'hA000_0000, 16'd4, 32'hDEAD_BEEF);
    wait_done("t4", 400);
    check("t4_err", err_count, 16'd1);
    check("t4_txn", txn_count, 16'd4);
    check("t4_pass", pass, 1'b0);
    check_queues("t4");
    bresp_idx = -1;

    // T5: AR never accepted -> timeout after 64 cycles
    clear_queues();
    ar_block = 1'b1;
    exp_aw_q.push_back(32'hA000_0000);
    exp_w_q.push_back(32'hDEAD_BEEF);
    pulse_start(32'hA000_0000, 16'd4, 32'hDEAD_BEEF);
    wait_done("t5", 400);
    check("t5_ar_held", 64'(last_ar_held), 64);
    check("t5_flags", {done, pass, timeout_err, busy}, 4'b1010);
    check("t5_txn", txn_count, 16'd0);
    check("t5_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    ar_block = 1'b0;
    exp_ar_q.delete();
    check_queues("t5");

    // T6: zero-length run finishes one cycle after start with pass
    clear_queues();
    pulse_start(32'hA000_0000, 16'd0, 32'hDEAD_BEEF);
    check("t6_done_pass", {done, pass, busy, timeout_err}, 4'b1100);
    check("t6_txn", txn_count, 16'd0);

    // T7: seed 0 becomes 1, address wraps past 2^32
    clear_queues();
    push_txn(32'hFFFF_FFFC, 32'h0000_0001);
    push_txn(32'h0000_0000, 32'h8020_0003);
    pulse_start(32'hFFFF_FFFC, 16'd2, 32'h0);
    wait_done("t7", 300);
    check("t7_txn", txn_count, 16'd2);
    check("t7_pass", pass, 1'b1);
    check_queues("t7");

    // T8: reset during RR of transaction 1, then a clean run
    clear_queues();
    push_seed_run(32'hA000_0000);
    pulse_start(32'hA000_0000, 16'd4, 32'hDEAD_BEEF);
    begin
      int k = 0;
      while (!(fsm_state == 3'd4 && araddr == 32'hA000_0004) && k < 300) begin
        @(negedge clk_wr);
        k++;
      end
      check("t8_reached_rr", {fsm_state, araddr}, {3'd4, 32'hA000_0004});
    end
    rst_wr_n = 1'b0;
    @(negedge clk_wr);
    check_idle_outputs("t8_reset");
    rst_wr_n = 1'b1;
    clear_queues();
    push_seed_run(32'hA000_0000);
    pulse_start(32'hA000_0000, 16'd4, 32'hDEAD_BEEF);
    wait_done("t8", 400);
    check("t8_txn", txn_count, 16'd4);
    check("t8_pass", pass, 1'b1);
    check_queues("t8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- global time bound ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_traffic_gen.md
Name: axi_lite_traffic_gen

Overview:
- AXI4-Lite master traffic generator. Sits directly upstream of the AIB AXI bridge master and drives its user AXI-Lite port.
- Performs NUM write-then-readback transactions using an LFSR data pattern, checks the read data, and reports pass/fail plus counters.
- Used for bring-up and loopback checking of the AIB AXI bridge path.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
TIMEOUT, 1024, max cycles waiting in any handshake state before abort (>=2)

Ports:
clk_wr  in  1  clock; all logic on rising edge
rst_wr_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; begins a run when idle
base_addr  in  ADDR_W  first transaction address, 4-byte aligned
num_txn  in  16  transactions per run
seed  in  32  LFSR seed; 0 is replaced by 32'h1
awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  AW channel
wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  W channel
bresp/bvalid/bready  in/in/out  2/1/1  B channel
araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AR channel
rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  R channel
busy  out  1  run in progress
done  out  1  level; run finished; held until next accepted start
pass  out  1  done && err_count==0 && !timeout_err
err_count  out  16  data mismatches plus non-OKAY responses, saturating at 16'hFFFF
txn_count  out  16  completed write+read pairs
timeout_err  out  1  run aborted on timeout

Behaviour:
- Reset (rst_wr_n=0 at an edge): all valid/ready outputs 0, busy/done/pass/timeout_err 0, counters 0, addr/data outputs 0, FSM IDLE, LFSR=1.
- FSM states: IDLE, WR, WB, RD, RR, NEXT, DONE.
- IDLE, and DONE on start:
  - Latch base_addr, num_txn and seed.
  - Clear counters and flags; set busy.
  - If num_txn==0, go to DONE (done=1, pass=1 the next cycle); otherwise go to WR.
  - start while busy is ignored.
- WR:
  - awvalid and wvalid rise 1 cycle after start (or after NEXT).
  - awaddr = base + idx*4; wdata = LFSR value.
  - Each valid drops the cycle after its own handshake; AW and W complete independently, in either order or together.
  - All address/data outputs stay stable while the corresponding valid is high.
  - When both handshakes are done, go to WB.
- WB:
  - bready=1; on bvalid, go to RD.
  - bresp!=2'b00 increments err_count.
- RD: arvalid=1 with araddr = same address; on arready, go to RR.
- RR:
  - rready=1; on rvalid, compare rdata against the stored expected data.
  - Mismatch or rresp!=0 increments err_count by 1 (both together count once).
  - Go to NEXT.
- NEXT:
  - txn_count++, idx++, LFSR advances one step (Galois, taps x^32+x^22+x^2+x+1).
  - If txn_count==num_txn go to DONE, else go to WR.
- DONE: busy=0, done=1, pass valid.
- Timeout:
  - Wait counter clears on state entry and counts while in WR/WB/RD/RR.
  - Reaching TIMEOUT: deassert all valids/readys, set timeout_err=1, go to DONE (deliberate protocol abort).
- Address arithmetic is modulo 2^ADDR_W (wraps silently).
- Reset mid-run: next edge returns to the reset state; no outstanding-handshake bookkeeping survives.

Optional Feature:
AXI_TG_RANDOM_STRB_EN
- Defined: wstrb = LFSR bits [DATA_W/8-1:0], forced to all-ones if zero. Readback compare is masked to the strobed bytes only; the strobe is stored with the expected data.
- Undefined: wstrb is all-ones and the full word is compared.

Test Plan:
1. Zero-wait memory slave, base=32'hA000_0000, num_txn=4, seed=32'hDEAD_BEEF -> AW addrs A0000000..A000000C in order, each read returns the written data, done=1, txn_count=4, err_count=0, pass=1.
2. awready delayed 3 cycles, wready immediate -> W completes first; awvalid/awaddr stable for 3 cycles, single AW handshake, exactly one B accepted, run passes.
3. Slave XORs rdata with 32'h1 on txn idx 2, num_txn=4 -> err_count=1, txn_count=4, pass=0.
4. bresp=2'b10 on txn 0 only -> err_count=1, all 4 pairs completed, pass=0.
5. arready tied 0, TIMEOUT=64 -> arvalid high exactly 64 cycles then low, timeout_err=1, done=1, pass=0, txn_count=0.
6. rst_wr_n pulsed low during RR of txn 1 -> next edge all valids/readys 0, busy=0, counters 0; a new start runs cleanly to pass=1.
